// File: rtl/mem_responder.sv
// Byte-addressed little-endian RAM on a req/ack handshake; ack lands WAIT_CYCLES+1 cycles after the req sample.
// Initiator holds req until ack; one access per WAIT_CYCLES+2 cycles; MEM_RESPONDER_ALIGN_CHECK_EN flags misaligned word/half.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [7:0]          mem [2**ADDR_W];

  logic                acc_wr;
  logic [ADDR_W-1:0]   acc_a;
  logic [31:0]         acc_wdata;
  logic [1:0]          acc_size;
  logic                acc_err;
  logic [ADDR_W-1:0]   base;
  logic [3:0]          lane_en;
  logic [31:0]         rd_word;
  logic                enter_ack;
  logic                mem_we;
  logic                unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  // With zero wait states the access shares the sampling edge, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      acc_wr    = wr;
      acc_a     = addr[ADDR_W-1:0];
      acc_wdata = wdata;
      acc_size  = size;
    end else begin
      acc_wr    = wr_q;
      acc_a     = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
    end
  end

  always_comb begin
    lane_en = 4'h0;
    base    = acc_a;
    acc_err = 1'b0;
    case (acc_size)
      2'b00: begin
        lane_en = 4'hF;
        base    = {acc_a[ADDR_W-1:2], 2'b00};
      end
      2'b01: begin
        lane_en = 4'h3;
        base    = {acc_a[ADDR_W-1:1], 1'b0};
      end
      2'b10:   lane_en = 4'h1;
      default: acc_err = 1'b1;
    endcase
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if ((acc_size == 2'b00 && acc_a[1:0] != 2'b00) || (acc_size == 2'b01 && acc_a[0]))
      acc_err = 1'b1;
`endif
    if (acc_err) lane_en = 4'h0;
  end

  always_comb begin
    rd_word = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) rd_word[8*i +: 8] = mem[base | ADDR_W'(i)];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    enter_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = wdata;
          size_d  = size;
          if (WAIT_CYCLES == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_d   = enter_ack ? acc_err : 1'b0;
    rdata_d = rdata_q;
    if (enter_ack && !acc_wr && !acc_err) rdata_d = rd_word;
    mem_we = enter_ack && acc_wr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; an async reset drops state_q to IDLE, which kills mem_we.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[base | ADDR_W'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ack   = (state_q == ACK);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench for mem_responder with a scoreboard of expected ack results.
module tb_mem_responder;
  localparam int WAITC = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;
  logic        ack, busy, err;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .size(size), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops one expected result.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("ack_rdata", rdata, e.rdata);
        check("ack_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  task automatic do_txn(input int idx, input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clock);
    req   = 1'b1;
    wr    = v.wr;
    addr  = v.addr;
    wdata = v.wdata;
    size  = v.size;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1 && !ack) begin
        wr    = ~v.wr;
        addr  = ~v.addr;
        wdata = ~v.wdata;
        size  = ~v.size;
      end
    end while (!ack && lat < 40);
    req = 1'b0;
    check($sformatf("latency[%0d]", idx), 32'(lat), 32'(WAITC + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first, second, n;
    exp_t e;

    vecs[0]  = '{1'b1, 2'b00, 32'h10,  32'h11223344, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 32'h10,  32'h0,        32'h11223344, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 32'h13,  32'h000000AB, 32'h11223344, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 32'h10,  32'h0,        32'hAB223344, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 32'h12,  32'h0,        32'h0000AB22, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 32'h11,  32'h0,        32'h00000033, 1'b0};
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    vecs[6]  = '{1'b0, 2'b00, 32'h11,  32'h0,        32'h00000033, 1'b1};
`else
    vecs[6]  = '{1'b0, 2'b00, 32'h11,  32'h0,        32'hAB223344, 1'b0};
`endif
    vecs[7]  = '{1'b0, 2'b00, 32'h110, 32'h0,        32'hAB223344, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 32'h10,  32'h0,        32'hAB223344, 1'b1};
    vecs[9]  = '{1'b1, 2'b11, 32'h10,  32'hFFFFFFFF, 32'hAB223344, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 32'h10,  32'h0,        32'hAB223344, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 32'h14,  32'h55667788, 32'hAB223344, 1'b0};
    vecs[12] = '{1'b1, 2'b01, 32'h16,  32'h1234CAFE, 32'hAB223344, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 32'h14,  32'h0,        32'hCAFE7788, 1'b0};
    vecs[14] = '{1'b1, 2'b00, 32'hFC,  32'hA1B2C3D4, 32'hCAFE7788, 1'b0};
    vecs[15] = '{1'b0, 2'b10, 32'h1FF, 32'h0,        32'h000000A1, 1'b0};
    vecs[16] = '{1'b1, 2'b00, 32'h20,  32'h01234567, 32'h000000A1, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 32'h20,  32'h0,        32'h01234567, 1'b0};

    // Reset held with req high: nothing may start.
    reset = 1'b0;
    req   = 1'b1;
    wr    = 1'b1;
    addr  = 32'h10;
    wdata = 32'hFFFFFFFF;
    size  = 2'b00;
    repeat (3) begin
      @(negedge clock);
      check("rst_ack",   {31'b0, ack},  32'h0);
      check("rst_busy",  {31'b0, busy}, 32'h0);
      check("rst_err",   {31'b0, err},  32'h0);
      check("rst_rdata", rdata,         32'h0);
    end
    req   = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 18; i++) do_txn(i, vecs[i]);

    // Back-to-back reads with req held high.
    @(negedge clock);
    req  = 1'b1;
    wr   = 1'b0;
    addr = 32'h20;
    size = 2'b00;
    e.rdata = 32'h01234567;
    e.err   = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    first  = -1;
    second = -1;
    n      = 0;
    while (second < 0 && n < 40) begin
      @(negedge clock);
      n++;
      if (ack) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    req = 1'b0;
    check("b2b_gap", 32'(second - first), 32'(WAITC + 2));

    // Reset during WAIT of a write must discard it.
    @(negedge clock);
    req   = 1'b1;
    wr    = 1'b1;
    addr  = 32'h20;
    wdata = 32'hDEADBEEF;
    size  = 2'b00;
    @(negedge clock);
    check("abort_busy_wait", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    req   = 1'b0;
    #1;
    check("abort_ack",  {31'b0, ack},  32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    check("abort_rdata", rdata, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    do_txn(100, '{1'b0, 2'b00, 32'h20, 32'h0, 32'h01234567, 1'b0});

    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
